// File: rtl/i2s_capture_pkg.sv
// Shared audio definitions for the I2S capture front end: FSM states, slot geometry
// and default sample/FIFO geometry and calibration.
package i2s_capture_pkg;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, WAIT_BUF} cap_state_t;

  localparam int SLOT_LEN       = 32;
  localparam int DEF_MIC_BITS   = 18;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam logic signed [DEF_MIC_BITS-1:0] DEF_CAL_OFFSET = 18'sd7232;

endpackage

// File: rtl/i2s_capture_if.sv
// Sample FIFO write port plus the buffer-ready hold-off from the FFT loader.
interface i2s_capture_if import i2s_capture_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MIC_BITS   = DEF_MIC_BITS
);
  logic                  sample_valid;
  logic [MIC_BITS-1:0]   sample_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  frame_done;
  logic                  overrun;
  logic                  buf_ready;

  modport master (
    output sample_valid, sample_data, wr_addr, frame_done, overrun,
    input  buf_ready
  );

  modport slave (
    input  sample_valid, sample_data, wr_addr, frame_done, overrun,
    output buf_ready
  );
endinterface

// File: rtl/i2s_wordclk_gen.sv
// Word clock generator: LRCLK toggles every SLOT_LEN falling edges of BCLK so the
// microphone sees it change well away from the capture edge.
module i2s_wordclk_gen import i2s_capture_pkg::*; (
  input  logic BCLK,
  input  logic rst,
  output logic LRCLK
);
  localparam int CW = $clog2(SLOT_LEN);

  logic [CW-1:0] slot_cnt;

  always_ff @(negedge BCLK or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      LRCLK    <= 1'b1;
    end else if (slot_cnt == CW'(SLOT_LEN - 1)) begin
      slot_cnt <= '0;
      LRCLK    <= ~LRCLK;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_capture.sv
// I2S single-channel capture: deserialise, add calibration offset with saturation,
// write to the sample FIFO; one sample per stereo frame, held off by buf_ready per frame.
module i2s_capture import i2s_capture_pkg::*; #(
  parameter int                         ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                         MIC_BITS   = DEF_MIC_BITS,
  parameter bit                         CHANNEL    = 1'b0,
  parameter logic signed [MIC_BITS-1:0] CAL_OFFSET = DEF_CAL_OFFSET
) (
  input  logic             BCLK,
  input  logic             rst,
  input  logic             DOUT,
  input  logic             capture_en,
  output logic             LRCLK,
  i2s_capture_if.master    bus
);
  localparam logic [4:0]            BIT_LAST  = 5'(MIC_BITS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  cap_state_t            state, state_nxt;
  logic                  ws_d;
  logic                  slot_start;
  logic                  slot_done;
  logic [4:0]            bit_idx;
  logic [MIC_BITS-1:0]   shreg;
  logic [MIC_BITS:0]     sum;
  logic [MIC_BITS-1:0]   sat;
  logic [ADDR_WIDTH-1:0] addr_cnt, addr_nxt, waddr_nxt;
  logic [MIC_BITS-1:0]   data_nxt;
  logic                  valid_nxt, frame_nxt, ovr_nxt;

  i2s_wordclk_gen u_wordclk (
    .BCLK  (BCLK),
    .rst   (rst),
    .LRCLK (LRCLK)
  );

  assign slot_start = (LRCLK != ws_d);
  assign slot_done  = (bit_idx == BIT_LAST) && (ws_d == CHANNEL);

  // The slot-start edge shifts nothing: I2S puts the MSB one bit after the WS change.
  always_ff @(posedge BCLK or negedge rst) begin
    if (!rst) begin
      ws_d    <= 1'b1;
      bit_idx <= 5'd31;
      shreg   <= '0;
    end else begin
      ws_d <= LRCLK;
      if (slot_start) begin
        bit_idx <= 5'd0;
      end else if (bit_idx < BIT_LAST) begin
        shreg   <= {shreg[MIC_BITS-2:0], DOUT};
        bit_idx <= bit_idx + 5'd1;
      end else begin
        bit_idx <= 5'd31;
      end
    end
  end

  assign sum = {shreg[MIC_BITS-1], shreg} + {CAL_OFFSET[MIC_BITS-1], CAL_OFFSET};

  always_comb begin
    sat = sum[MIC_BITS-1:0];
    if (sum[MIC_BITS] != sum[MIC_BITS-1])
      sat = sum[MIC_BITS] ? {1'b1, {(MIC_BITS-1){1'b0}}} : {1'b0, {(MIC_BITS-1){1'b1}}};
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_cnt;
    waddr_nxt = bus.wr_addr;
    data_nxt  = bus.sample_data;
    valid_nxt = 1'b0;
    frame_nxt = 1'b0;
    ovr_nxt   = bus.overrun;
    if (!capture_en) begin
      state_nxt = IDLE;
      addr_nxt  = '0;
      waddr_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          ovr_nxt   = 1'b0;
        end
        ARM: begin
          if (slot_start && (LRCLK == CHANNEL)) begin
            state_nxt = CAPTURE;
            addr_nxt  = '0;
          end
        end
        CAPTURE: begin
          if (slot_done) begin
            valid_nxt = 1'b1;
            data_nxt  = sat;
            waddr_nxt = addr_cnt;
            addr_nxt  = addr_cnt + ADDR_WIDTH'(1);
            if (addr_cnt == ADDR_LAST) begin
              frame_nxt = 1'b1;
              if (!bus.buf_ready) state_nxt = WAIT_BUF;
            end
          end
        end
        WAIT_BUF: begin
          if (slot_done) ovr_nxt = 1'b1;
          if (bus.buf_ready) state_nxt = ARM;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge BCLK or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      addr_cnt         <= '0;
      bus.sample_valid <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.sample_data  <= '0;
      bus.wr_addr      <= '0;
    end else begin
      state            <= state_nxt;
      addr_cnt         <= addr_nxt;
      bus.sample_valid <= valid_nxt;
      bus.frame_done   <= frame_nxt;
      bus.overrun      <= ovr_nxt;
      bus.sample_data  <= data_nxt;
      bus.wr_addr      <= waddr_nxt;
    end
  end

endmodule
